if_id_pipe: RTL and testbench

Parametrised IF/ID pipeline register with a valid/ready handshake, a one-entry skid buffer and a flush input. It sits between the fetch stage and the decoder. It replaces a plain always-load register, so that decode back-pressure (hazard stalls, multi-cycle ops) and branch/trap flushes are handled without dropping or duplicating instructions. Full throughput is one instruction per cycle, and there is no combinational path from `id_ready` to `if_ready`.

---
 rtl/if_id_pipe.sv | 102 ++++++++++
 tb/tb_if_id_pipe.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_pipe.sv
// IF/ID pipeline register with valid/ready handshake, a one-entry skid
// buffer and a flush input. The skid register lets the upstream ready
// come purely from registered state, so id_ready never reaches if_ready
// combinationally while still sustaining one instruction per cycle.
module if_id_pipe #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(32'h0000_0013)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic [INST_W-1:0] if_inst,
  input  logic              flush,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst
);

  // Output (decode-facing) register
  logic              id_valid_reg, id_valid_next;
  logic [ADDR_W-1:0] id_pc_reg,    id_pc_next;
  logic [INST_W-1:0] id_inst_reg,  id_inst_next;

  // Skid register: catches the one beat accepted while the output stalls
  logic              skid_v_reg,    skid_v_next;
  logic [ADDR_W-1:0] skid_pc_reg,   skid_pc_next;
  logic [INST_W-1:0] skid_inst_reg, skid_inst_next;

  logic in_acc;
  logic out_free;

  // Ready depends only on the skid flag (and reset), never on id_ready
  assign if_ready = !skid_v_reg && !rst;
  assign in_acc   = if_valid && if_ready;
  assign out_free = !id_valid_reg || id_ready;

  assign id_valid = id_valid_reg;
  assign id_pc    = id_pc_reg;
  assign id_inst  = id_inst_reg;

  // Next-state selection: flush beats normal flow; reset is applied in the flop
  always_comb begin
    id_valid_next  = id_valid_reg;
    id_pc_next     = id_pc_reg;
    id_inst_next   = id_inst_reg;
    skid_v_next    = skid_v_reg;
    skid_pc_next   = skid_pc_reg;
    skid_inst_next = skid_inst_reg;

    if (flush) begin
      // Drop everything held and whatever is accepted this cycle; PC is kept
      id_valid_next = 1'b0;
      id_inst_next  = NOP_INST;
      skid_v_next   = 1'b0;
    end else if (out_free) begin
      if (skid_v_reg) begin
        // Drain the skid first; if_ready is low so nothing new arrives
        id_valid_next = 1'b1;
        id_pc_next    = skid_pc_reg;
        id_inst_next  = skid_inst_reg;
        skid_v_next   = 1'b0;
      end else if (in_acc) begin
        id_valid_next = 1'b1;
        id_pc_next    = if_pc;
        id_inst_next  = if_inst;
      end else begin
        // Bubble: present a NOP so a careless decoder sees harmless code
        id_valid_next = 1'b0;
        id_inst_next  = NOP_INST;
      end
    end else if (in_acc) begin
      // Output is stalled with valid data: park the incoming beat
      skid_v_next    = 1'b1;
      skid_pc_next   = if_pc;
      skid_inst_next = if_inst;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid_reg  <= 1'b0;
      id_pc_reg     <= '0;
      id_inst_reg   <= NOP_INST;
      skid_v_reg    <= 1'b0;
      skid_pc_reg   <= '0;
      skid_inst_reg <= NOP_INST;
    end else begin
      id_valid_reg  <= id_valid_next;
      id_pc_reg     <= id_pc_next;
      id_inst_reg   <= id_inst_next;
      skid_v_reg    <= skid_v_next;
      skid_pc_reg   <= skid_pc_next;
      skid_inst_reg <= skid_inst_next;
    end
  end

endmodule

// File: tb/tb_if_id_pipe.sv
// Bench for if_id_pipe: directed vectors on a default-parameter instance,
// then a random valid/ready scoreboard on a 64-bit PC / 16-bit instruction
// instance.
module tb_if_id_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: default parameters
  logic        a_rst, a_if_valid, a_if_ready, a_flush, a_id_valid, a_id_ready;
  logic [31:0] a_if_pc, a_if_inst, a_id_pc, a_id_inst;

  if_id_pipe dut_a (
    .clk(clk), .rst(a_rst),
    .if_valid(a_if_valid), .if_ready(a_if_ready),
    .if_pc(a_if_pc), .if_inst(a_if_inst),
    .flush(a_flush),
    .id_valid(a_id_valid), .id_ready(a_id_ready),
    .id_pc(a_id_pc), .id_inst(a_id_inst)
  );

  // Instance B: wide PC, narrow instruction
  logic        b_rst, b_if_valid, b_if_ready, b_flush, b_id_valid, b_id_ready;
  logic [63:0] b_if_pc, b_id_pc;
  logic [15:0] b_if_inst, b_id_inst;

  if_id_pipe #(.ADDR_W(64), .INST_W(16)) dut_b (
    .clk(clk), .rst(b_rst),
    .if_valid(b_if_valid), .if_ready(b_if_ready),
    .if_pc(b_if_pc), .if_inst(b_if_inst),
    .flush(b_flush),
    .id_valid(b_id_valid), .id_ready(b_id_ready),
    .id_pc(b_id_pc), .id_inst(b_id_inst)
  );

  localparam logic [31:0] NOP32 = 32'h0000_0013;
  localparam logic [15:0] NOP16 = 16'h0013;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  // Advance one clock; inputs change and outputs are checked 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer_a(input logic v, input logic [31:0] pc);
    a_if_valid = v;
    a_if_pc    = pc;
    a_if_inst  = inst_of(pc);
    #1;
  endtask

  task automatic expect_a(input string tag, input logic v, input logic [31:0] pc,
                          input logic [31:0] inst);
    check({tag, "_valid"}, {63'd0, a_id_valid}, {63'd0, v});
    check({tag, "_pc"},    {32'd0, a_id_pc},    {32'd0, pc});
    check({tag, "_inst"},  {32'd0, a_id_inst},  {32'd0, inst});
  endtask

  // Scoreboard state for instance B
  typedef struct packed { logic [63:0] pc; logic [15:0] inst; } beat_t;
  beat_t       sb_q[$];
  logic        prev_stall = 1'b0;
  logic [63:0] prev_pc;
  logic [15:0] prev_inst;
  logic [63:0] next_pc;
  logic [15:0] next_inst;

  // One observation of instance B, taken mid-cycle before the next edge
  task automatic observe_b();
    beat_t exp_b;
    if (prev_stall) begin
      check("rnd_stall_valid", {63'd0, b_id_valid}, 64'd1);
      check("rnd_stall_pc",    b_id_pc, prev_pc);
      check("rnd_stall_inst",  {48'd0, b_id_inst}, {48'd0, prev_inst});
    end
    if (!b_id_valid) check("rnd_nop", {48'd0, b_id_inst}, {48'd0, NOP16});
    if (b_id_valid && b_id_ready) begin
      check("rnd_sb_nonempty", {63'd0, (sb_q.size() != 0)}, 64'd1);
      if (sb_q.size() != 0) begin
        exp_b = sb_q.pop_front();
        check("rnd_pc",   b_id_pc, exp_b.pc);
        check("rnd_inst", {48'd0, b_id_inst}, {48'd0, exp_b.inst});
      end
    end
    if (b_if_valid && b_if_ready) begin
      sb_q.push_back('{pc: b_if_pc, inst: b_if_inst});
      next_pc   = next_pc + 64'h4;
      next_inst = 16'($urandom);
    end
    prev_stall = b_id_valid && !b_id_ready;
    prev_pc    = b_id_pc;
    prev_inst  = b_id_inst;
  endtask

  initial begin
    a_rst = 1'b1; a_flush = 1'b0; a_id_ready = 1'b0;
    b_rst = 1'b1; b_flush = 1'b0; b_id_ready = 1'b0; b_if_valid = 1'b0;
    b_if_pc = '0; b_if_inst = '0;
    offer_a(1'b1, 32'h40);

    // Reset held for two cycles with fetch offering a beat
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_if_ready", {63'd0, a_if_ready}, 64'd0);
      expect_a("rst", 1'b0, 32'h0, NOP32);
    end
    a_rst = 1'b0; b_rst = 1'b0;
    offer_a(1'b0, 32'h0);
    check("post_rst_if_ready", {63'd0, a_if_ready}, 64'd1);

    // Streaming: back-to-back with the decoder always ready
    a_id_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      offer_a(1'b1, 32'(4 * k));
      check("stream_if_ready", {63'd0, a_if_ready}, 64'd1);
      step();
      expect_a("stream", 1'b1, 32'(4 * k), inst_of(32'(4 * k)));
    end
    offer_a(1'b0, 32'h0);
    step();
    expect_a("stream_end", 1'b0, 32'hC, NOP32);

    // Stall with skid capture, then release
    offer_a(1'b1, 32'h100);
    step();
    expect_a("stall_load", 1'b1, 32'h100, inst_of(32'h100));
    a_id_ready = 1'b0;
    offer_a(1'b1, 32'h104);
    check("stall_if_ready_first", {63'd0, a_if_ready}, 64'd1);
    step();
    expect_a("stall1", 1'b1, 32'h100, inst_of(32'h100));
    check("stall1_if_ready", {63'd0, a_if_ready}, 64'd0);
    offer_a(1'b1, 32'h108);
    step();
    expect_a("stall2", 1'b1, 32'h100, inst_of(32'h100));
    check("stall2_if_ready", {63'd0, a_if_ready}, 64'd0);
    step();
    expect_a("stall3", 1'b1, 32'h100, inst_of(32'h100));
    a_id_ready = 1'b1;
    step();
    expect_a("release_skid", 1'b1, 32'h104, inst_of(32'h104));
    check("release_if_ready", {63'd0, a_if_ready}, 64'd1);
    step();
    expect_a("release_next", 1'b1, 32'h108, inst_of(32'h108));
    offer_a(1'b0, 32'h0);
    step();
    check("release_drained", {63'd0, a_id_valid}, 64'd0);

    // Flush while output and skid are both full
    a_id_ready = 1'b0;
    offer_a(1'b1, 32'h200);
    step();
    offer_a(1'b1, 32'h204);
    step();
    check("fl_full_if_ready", {63'd0, a_if_ready}, 64'd0);
    a_flush = 1'b1;
    offer_a(1'b1, 32'h208);
    step();
    expect_a("flush", 1'b0, 32'h200, NOP32);
    check("flush_if_ready", {63'd0, a_if_ready}, 64'd1);
    a_flush = 1'b0; a_id_ready = 1'b1;
    offer_a(1'b1, 32'h300);
    step();
    expect_a("post_flush", 1'b1, 32'h300, inst_of(32'h300));
    // Flush discards a beat that is actually accepted the same cycle
    a_flush = 1'b1;
    offer_a(1'b1, 32'h304);
    check("flush_acc_if_ready", {63'd0, a_if_ready}, 64'd1);
    step();
    expect_a("flush_acc", 1'b0, 32'h300, NOP32);
    a_flush = 1'b0;

    // Bubbles in the fetch stream
    offer_a(1'b1, 32'h400);
    step();
    expect_a("bub1", 1'b1, 32'h400, inst_of(32'h400));
    offer_a(1'b0, 32'h404);
    step();
    expect_a("bub0", 1'b0, 32'h400, NOP32);
    offer_a(1'b1, 32'h408);
    step();
    expect_a("bub2", 1'b1, 32'h408, inst_of(32'h408));

    // Reset and flush together: reset wins, PC cleared
    a_rst = 1'b1; a_flush = 1'b1;
    offer_a(1'b0, 32'h0);
    check("rstfl_if_ready", {63'd0, a_if_ready}, 64'd0);
    step();
    expect_a("rstfl", 1'b0, 32'h0, NOP32);
    a_rst = 1'b0; a_flush = 1'b0;
    #1;
    check("rstfl_after_if_ready", {63'd0, a_if_ready}, 64'd1);

    // Random valid/ready traffic on the wide instance
    next_pc   = 64'hFFFF_0000_0000_0000;
    next_inst = 16'($urandom);
    for (int c = 0; c < 10000; c++) begin
      @(posedge clk);
      #1;
      b_if_valid = ($urandom_range(0, 3) != 0);
      b_id_ready = ($urandom_range(0, 2) != 0);
      b_if_pc    = next_pc;
      b_if_inst  = next_inst;
      @(negedge clk);
      observe_b();
    end
    // Drain what is still held
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      b_if_valid = 1'b0;
      b_id_ready = 1'b1;
      @(negedge clk);
      observe_b();
    end
    check("rnd_drained", 64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
